// File: rtl/sw_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_mode_pkg
// Description : Shared definitions for the switch mode decoder.
//               - Pattern-mode codes understood by the LED pattern generator.
//               - Legality check for a 4-bit switch code.
//               - Debounce FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_mode_pkg;

    // Pattern-mode codes (one per legal switch setting)
    localparam logic [3:0] MODE_SHIFT  = 4'b0000;
    localparam logic [3:0] MODE_BLINK  = 4'b1000;
    localparam logic [3:0] MODE_FAST   = 4'b0100;
    localparam logic [3:0] MODE_SLOW   = 4'b0010;
    localparam logic [3:0] MODE_BOUNCE = 4'b0001;
    localparam logic [3:0] MODE_PAIR   = 4'b1100;
    localparam logic [3:0] MODE_ALT    = 4'b1010;
    localparam logic [3:0] MODE_EDGE   = 4'b1001;
    localparam logic [3:0] MODE_FILL   = 4'b1110;
    localparam logic [3:0] MODE_GAP    = 4'b1101;
    localparam logic [3:0] MODE_CLEAR  = 4'b1111;

    // Debounce FSM states
    typedef enum logic [1:0] {
        STABLE   = 2'd0,
        SETTLING = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    // Returns 1 when the code belongs to the legal pattern-mode set.
    function automatic logic is_legal_mode(input logic [3:0] code);
        logic legal;
        legal = 1'b0;
        case (code)
            MODE_SHIFT, MODE_BLINK, MODE_FAST, MODE_SLOW, MODE_BOUNCE,
            MODE_PAIR, MODE_ALT, MODE_EDGE, MODE_FILL, MODE_GAP,
            MODE_CLEAR: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_mode_decoder_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : N-stage, W-bit flip-flop synchroniser for asynchronous inputs.
//               The output is d_i delayed by STAGES clock cycles.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset (loads RESET_VAL)
//               d_i   - asynchronous input vector
//               q_o   - synchronised output vector
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int unsigned   STAGES    = 2,
    parameter int unsigned   W         = 4,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // stage_q[0] is the first (metastability-exposed) stage
    logic [STAGES-1:0][W-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {STAGES{RESET_VAL}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sw_mode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sw_mode_decoder
// Description : Converts raw board switches into a clean, debounced and
//               validated pattern-mode code with a one-cycle change strobe.
// Ports       : clk           - system clock
//               rst_n         - asynchronous active-low reset
//               sw_i[3:0]     - raw asynchronous switch inputs
//               mode_o[3:0]   - committed, legal mode code
//               mode_change_o - one-cycle pulse when mode_o takes a new value
//               illegal_o     - last committed switch code was not legal
//               busy_o        - a switch change is being debounced
// Revision    : 1.0 - initial release
// ============================================================================
module sw_mode_decoder
    import sw_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [3:0]  RESET_MODE      = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_i,
    output logic [3:0] mode_o,
    output logic       mode_change_o,
    output logic       illegal_o,
    output logic       busy_o
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_sw;
    state_t           state_q;
    logic [3:0]       raw_last_q;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             commit_q;
    logic [3:0]       commit_code_q;
    logic [3:0]       mode_q;
    logic             mode_change_q;
    logic             illegal_q;
    logic             busy_q;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .W         (4),
        .RESET_VAL (RESET_MODE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw_i),
        .q_o   (sync_sw)
    );

    // Debounce FSM plus output stage. The COMMIT state hands the candidate
    // to a one-cycle commit register; the output registers act on it the
    // following cycle, so mode/strobe/illegal and the falling edge of busy
    // all land on the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= STABLE;
            raw_last_q    <= RESET_MODE;
            cand_q        <= RESET_MODE;
            cnt_q         <= '0;
            commit_q      <= 1'b0;
            commit_code_q <= RESET_MODE;
            mode_q        <= RESET_MODE;
            mode_change_q <= 1'b0;
            illegal_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            commit_q      <= 1'b0;
            mode_change_q <= 1'b0;
            busy_q        <= (state_q != STABLE);

            case (state_q)
                STABLE: begin
                    if (sync_sw != raw_last_q) begin
                        state_q <= SETTLING;
                        cand_q  <= sync_sw;
                        cnt_q   <= '0;
                    end
                end
                SETTLING: begin
                    // Any bounce restarts the hold window on the new value
                    if (sync_sw != cand_q) begin
                        cand_q <= sync_sw;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    // raw_last follows the switches even for illegal codes so
                    // an unchanged illegal setting is not re-debounced forever
                    raw_last_q    <= cand_q;
                    commit_q      <= 1'b1;
                    commit_code_q <= cand_q;
                    state_q       <= STABLE;
                end
                default: begin
                    state_q <= STABLE;
                end
            endcase

            if (commit_q) begin
                if (is_legal_mode(commit_code_q)) begin
                    illegal_q <= 1'b0;
                    if (commit_code_q != mode_q) begin
                        mode_q        <= commit_code_q;
                        mode_change_q <= 1'b1;
                    end
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign mode_o        = mode_q;
    assign mode_change_o = mode_change_q;
    assign illegal_o     = illegal_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_mode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_mode_decoder
// Description : Scoreboard testbench for sw_mode_decoder (DEBOUNCE_CYCLES=8,
//               SYNC_STAGES=2). Stimulus pushes expected strobes; a monitor
//               pops and compares every mode_change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_mode_decoder;

    localparam int unsigned DEB  = 8;
    localparam int unsigned SYNC = 2;
    localparam int          LAT  = SYNC + DEB + 2;

    typedef struct {
        logic [3:0] mode;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] mode;
    logic       mode_change;
    logic       illegal;
    logic       busy;

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic prev_mc;

    sw_mode_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .RESET_MODE      (4'b1111)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_i          (sw),
        .mode_o        (mode),
        .mode_change_o (mode_change),
        .illegal_o     (illegal),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    initial prev_mc = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mode_change) begin
            checks++;
            if (prev_mc) begin
                errors++;
                $display("FAIL strobe_width: mode_change high two cycles in a row (cycle %0d)", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got mode %0h at cycle %0d, none expected", mode, cyc);
            end else begin
                e = exp_q.pop_front();
                if (mode != e.mode || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got mode %0h at cycle %0d expected mode %0h at cycle %0d",
                             mode, cyc, e.mode, e.cyc);
                end
            end
        end
        prev_mc = mode_change;
    end

    task automatic push_exp(input logic [3:0] m, input int c);
        exp_t e;
        e.mode = m;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Change sw at a negedge; returns the cycle count seen after the sampling edge
    task automatic set_sw(input logic [3:0] v, output int e0);
        sw = v;
        e0 = cyc + 1;
    endtask

    initial begin
        int e0;
        int r;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sw     = 4'b1111;

        // 1. Reset values, then hold 1111
        repeat (3) @(negedge clk);
        chk("reset_mode", mode, 4'b1111);
        chk("reset_strobe", mode_change, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end
        chk("idle_mode", mode, 4'b1111);
        chk("idle_illegal", illegal, 0);

        // 2. Clean change 1111 -> 0100
        set_sw(4'b0100, e0);
        push_exp(4'b0100, e0 + LAT);
        wait_cyc(e0 + 2);
        chk("clean_busy_pre", busy, 0);
        wait_cyc(e0 + 3);
        chk("clean_busy_rise", busy, 1);
        wait_cyc(e0 + LAT - 1);
        chk("clean_mode_pre", mode, 4'b1111);
        chk("clean_busy_hold", busy, 1);
        wait_cyc(e0 + LAT);
        chk("clean_mode", mode, 4'b0100);
        chk("clean_busy_fall", busy, 0);
        wait_cyc(e0 + LAT + 1);
        chk("clean_strobe_off", mode_change, 0);

        // 3. Bounce 0000/0001 every 3 cycles, then hold 0001
        for (int i = 0; i < 7; i++) begin
            set_sw((i % 2 == 0) ? 4'b0000 : 4'b0001, e0);
            repeat (3) begin
                @(negedge clk);
                chk("bounce_mode_hold", mode, 4'b0100);
            end
        end
        set_sw(4'b0001, e0);
        push_exp(4'b0001, e0 + LAT);
        wait_cyc(e0 + LAT - 1);
        chk("bounce_mode_pre", mode, 4'b0100);
        wait_cyc(e0 + LAT);
        chk("bounce_mode", mode, 4'b0001);
        wait_cyc(e0 + LAT + 5);

        // 4. Illegal code, then a legal one
        set_sw(4'b0011, e0);
        wait_cyc(e0 + LAT - 1);
        chk("illegal_pre", illegal, 0);
        wait_cyc(e0 + LAT);
        chk("illegal_set", illegal, 1);
        chk("illegal_mode_hold", mode, 4'b0001);
        wait_cyc(e0 + LAT + 5);
        chk("illegal_sticky", illegal, 1);
        set_sw(4'b1010, e0);
        push_exp(4'b1010, e0 + LAT);
        wait_cyc(e0 + LAT - 1);
        chk("legal_illegal_pre", illegal, 1);
        wait_cyc(e0 + LAT);
        chk("legal_mode", mode, 4'b1010);
        chk("legal_illegal_clr", illegal, 0);
        wait_cyc(e0 + LAT + 5);

        // 5. Same-value return: 1010 -> 1011 (4 cycles) -> 1010
        set_sw(4'b1011, e0);
        wait_cyc(e0 + 3);
        chk("return_busy", busy, 1);
        set_sw(4'b1010, e0);
        wait_cyc(e0 + 30);
        chk("return_mode", mode, 4'b1010);
        chk("return_busy_idle", busy, 0);
        chk("return_illegal", illegal, 0);

        // 6. Reset mid-debounce, release with sw still at 1100
        set_sw(4'b1100, e0);
        wait_cyc(e0 + 8);
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mode", mode, 4'b1111);
        chk("async_busy", busy, 0);
        chk("async_strobe", mode_change, 0);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push_exp(4'b1100, r + 1 + LAT);
        wait_cyc(r + LAT);
        chk("rel_mode_pre", mode, 4'b1111);
        wait_cyc(r + 1 + LAT);
        chk("rel_mode", mode, 4'b1100);
        wait_cyc(r + 1 + LAT + 20);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_mode_decoder.md
Name: sw_mode_decoder

Overview:
Input-side counterpart to the LED pattern generator. It reads the raw board switches and converts them into a clean, debounced, validated mode code.
- Synchronises sw[3:0] into the clk domain.
- Debounces the whole 4-bit vector as one value.
- Checks the result against the legal pattern-mode set.
- Presents a stable mode plus a one-cycle change strobe to the pattern generator, so the generator never sees glitching or illegal switch codes.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles sw must hold an identical value before commit (10 ms at 100 MHz); minimum 2
SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2
RESET_MODE, 4'b1111, mode presented after reset (the "all LEDs off / clear" mode)

Ports:
clk  input  1  system clock
rst_n  input  1  reset
sw  input  4  raw asynchronous switch inputs
mode  output  4  committed, legal mode code
mode_change  output  1  one-cycle pulse in the cycle mode takes a new value
illegal  output  1  high while the last committed switch code is not a legal mode
busy  output  1  high while a switch change is being debounced (state != STABLE)

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.

Behaviour:
- Reset values (async, rst_n low):
  - mode = RESET_MODE; mode_change = 0; illegal = 0; busy = 0.
  - State = STABLE, raw_last = RESET_MODE, cand = RESET_MODE, cnt = 0, sync chain = RESET_MODE.
- Legal mode set: 0000, 1000, 0100, 0010, 0001, 1100, 1010, 1001, 1110, 1101, 1111. Every other code is illegal.
- Synchroniser: sync_sw is sw delayed SYNC_STAGES cycles. Only sync_sw is used downstream.
- State STABLE:
  - If sync_sw != raw_last: go to SETTLING, cand <= sync_sw, cnt <= 0.
  - Otherwise stay.
- State SETTLING:
  - If sync_sw != cand: cand <= sync_sw, cnt <= 0 (restart; bounce).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to COMMIT.
  - Else cnt <= cnt+1.
  - If sync_sw returns to raw_last and then holds for DEBOUNCE_CYCLES, the commit still happens, but the no-change rule below applies.
- State COMMIT (exactly one cycle), then always go to STABLE. raw_last <= cand in all cases. Then:
  - cand legal and cand != mode: mode <= cand, mode_change <= 1 for one cycle, illegal <= 0.
  - cand legal and cand == mode: mode unchanged, no strobe, illegal <= 0.
  - cand illegal: mode holds its previous value, no strobe, illegal <= 1. illegal stays high until the next legal commit.
- Latency: with sw changing once and then held, mode and mode_change update exactly SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles after the first clk edge that samples the new sw value.
- Counter width: clog2(DEBOUNCE_CYCLES). cnt never wraps; its terminal compare is exact.
- mode_change is never high two cycles in a row. The minimum spacing between strobes is DEBOUNCE_CYCLES + 2.
- Reset mid-debounce: async clear to reset values; the pending candidate is discarded.
- After reset release with sw != RESET_MODE, a normal debounce and commit follows.

Decomposition:
- Package sw_mode_pkg holds:
  - localparam mode codes (MODE_SHIFT = 4'b0000, MODE_FAST = 4'b0100, MODE_CLEAR = 4'b1111, etc.);
  - function is_legal_mode(logic [3:0]) returning 1 for the legal set;
  - state enum {STABLE, SETTLING, COMMIT}.
- One sub-module: sync_chain, a parameterised N-stage, W-bit synchroniser with async active-low reset and a reset-value parameter.
- Debounce FSM and validation stay in the top module.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
1. Reset, then sw held at 1111 for 50 cycles -> mode=1111, mode_change never pulses, busy stays 0, illegal=0.
2. Clean change sw 1111->0100 -> busy rises 3 cycles after the sampling edge; mode=0100 and a single-cycle mode_change pulse exactly 12 cycles after the sampling edge; busy falls on the same edge.
3. Bounce: sw toggles 0000/0001 every 3 cycles for 20 cycles, then holds 0001 -> mode stays at its previous value throughout the bounce; mode=0001 exactly 12 cycles after the last toggle edge; one strobe only.
4. Illegal code: sw 0001->0011 held -> after 12 cycles illegal=1, mode stays 0001, no strobe. Then sw->1010 -> after 12 cycles mode=1010, strobe, illegal=0.
5. Same-value return: sw 1010->1011->1010, each held for only 4 cycles, then held at 1010 -> no commit of 1011, no strobe, mode stays 1010, busy eventually 0.
6. Reset mid-debounce: sw->1100, assert rst_n low at cycle 6 of SETTLING -> mode=1111, busy=0 immediately (async). Release with sw=1100 -> mode=1100 with strobe 12 cycles after release.
